// File: rtl/niu_sio_rsp_pkg.sv
// Shared constants, FSM state type, response record and parity helper for the
// SIU->NIU DMA-response receiver.
package niu_sio_rsp_pkg;

  localparam int HDR_W     = 128;
  localparam int BEAT_W    = 128;
  localparam int NUM_BEATS = 4;
  localparam int PAR_W     = 8;
  localparam int LANE_W    = BEAT_W / PAR_W;
  localparam int DATA_W    = BEAT_W * NUM_BEATS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_BEAT = 2'd2
  } state_t;

  typedef struct packed {
    logic [HDR_W-1:0]  hdr;
    logic [DATA_W-1:0] data;
    logic              has_data;
    logic              par_err;
  } rsp_t;

  // A lane is bad when its data-plus-parity XOR disagrees with the chosen sense.
  function automatic logic lane_par_err(input logic [BEAT_W-1:0] d,
                                        input logic [PAR_W-1:0]  p,
                                        input logic              odd);
    logic err;
    err = 1'b0;
    for (int i = 0; i < PAR_W; i++) begin
      err = err | ((^d[i*LANE_W +: LANE_W]) ^ p[i] ^ odd);
    end
    return err;
  endfunction

endpackage

// File: rtl/niu_sio_rsp_fifo.sv
// DEPTH-entry valid/ready buffer of response records; head reads as zero when
// the buffer is empty.
module niu_sio_rsp_fifo
  import niu_sio_rsp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  rsp_t push_data,
  output logic full,
  input  logic pop,
  output logic vld,
  output rsp_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    cnt;
  logic           wr_en;
  logic           rd_en;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign vld   = (cnt != '0);
  assign rd_en = pop && vld;
  // A full buffer can still take a push when the head leaves in the same cycle.
  assign wr_en = push && (!full || rd_en);
  assign head  = vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= AW'(wr_ptr + 1);
      if (rd_en) rd_ptr <= AW'(rd_ptr + 1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= (AW+1)'(cnt + 1);
        2'b01:   cnt <= (AW+1)'(cnt - 1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/niu_sio_rsp_rcv.sv
// NIU receiver for SIU DMA responses: captures header plus optional 4-beat
// payload, checks lane parity, and buffers whole packets, dropping on overflow.
module niu_sio_rsp_rcv
  import niu_sio_rsp_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int PAR_ODD = 1
) (
  input  logic                iol2clk,
  input  logic                arst_l,
  input  logic                sio_niu_hdr_vld,
  input  logic                sio_niu_datareq,
  input  logic [BEAT_W-1:0]   sio_niu_data,
  input  logic [PAR_W-1:0]    sio_niu_parity,
  output logic                rsp_vld,
  input  logic                rsp_rdy,
  output logic [HDR_W-1:0]    rsp_hdr,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_has_data,
  output logic                rsp_par_err,
  output logic                drop_pls,
  output logic                proto_err_pls,
  output logic [7:0]          drop_cnt
);

  localparam logic ODD = (PAR_ODD != 0);

  state_t                             state;
  state_t                             state_nxt;
  logic [1:0]                         beat_cnt;
  logic [HDR_W-1:0]                   hdr_q;
  logic [NUM_BEATS-2:0][BEAT_W-1:0]   beat_q;
  logic                               err_q;
  logic                               cyc_err;
  logic                               push;
  rsp_t                               push_rec;
  logic                               full;
  logic                               pop;
  logic                               drop;
  rsp_t                               head;

  assign cyc_err = lane_par_err(sio_niu_data, sio_niu_parity, ODD);
  assign pop     = rsp_vld && rsp_rdy;
  assign drop    = push && full && !pop;

  always_comb begin
    state_nxt     = state;
    proto_err_pls = 1'b0;
    push          = 1'b0;
    push_rec      = '0;
    case (state)
      ST_IDLE: begin
        if (sio_niu_hdr_vld) begin
          if (sio_niu_datareq) begin
            state_nxt = ST_GAP;
          end else begin
            push             = 1'b1;
            push_rec.hdr     = sio_niu_data;
            push_rec.par_err = cyc_err;
          end
        end
      end
      ST_GAP: begin
        proto_err_pls = sio_niu_hdr_vld;
        state_nxt     = ST_BEAT;
      end
      ST_BEAT: begin
        proto_err_pls = sio_niu_hdr_vld;
        // The last beat goes straight into the record rather than via beat_q.
        if (beat_cnt == 2'd3) begin
          push              = 1'b1;
          push_rec.hdr      = hdr_q;
          push_rec.data     = {sio_niu_data, beat_q};
          push_rec.has_data = 1'b1;
          push_rec.par_err  = err_q | cyc_err;
          state_nxt         = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iol2clk or negedge arst_l) begin
    if (!arst_l) begin
      state    <= ST_IDLE;
      beat_cnt <= 2'd0;
      hdr_q    <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
      drop_pls <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      drop_pls <= drop;
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      if ((state == ST_IDLE) && sio_niu_hdr_vld) begin
        hdr_q    <= sio_niu_data;
        err_q    <= cyc_err;
        beat_cnt <= 2'd0;
      end
      if (state == ST_BEAT) begin
        if (beat_cnt != 2'd3) beat_q[beat_cnt] <= sio_niu_data;
        err_q    <= err_q | cyc_err;
        beat_cnt <= beat_cnt + 2'd1;
      end
    end
  end

  niu_sio_rsp_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (iol2clk),
    .rst_n     (arst_l),
    .push      (push),
    .push_data (push_rec),
    .full      (full),
    .pop       (pop),
    .vld       (rsp_vld),
    .head      (head)
  );

  assign rsp_hdr      = head.hdr;
  assign rsp_data     = head.data;
  assign rsp_has_data = head.has_data;
  assign rsp_par_err  = head.par_err;

endmodule
